// File: rtl/icnd_pkg.sv
// Shared types and constants for the ICND pattern generator.
// Level mapping depends on the ICND_GAMMA_EN macro (gamma when defined, identity otherwise).
package icnd_pkg;

    localparam int ICND_CHANNELS = 16;
    localparam int WORD_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } icnd_state_e;

    function automatic logic [7:0] icnd_level_map(input logic [7:0] lvl);
`ifdef ICND_GAMMA_EN
        logic [15:0] sq;
        sq = {8'b0, lvl} * {8'b0, lvl};
        return sq[15:8];
`else
        return lvl;
`endif
    endfunction

endpackage

// File: rtl/icnd_pattern_gen_if.sv
// Word stream from the pattern generator to the serializer.
interface icnd_pattern_gen_if;

    logic [icnd_pkg::WORD_W-1:0] data;
    logic                        valid;
    logic                        ready;
    logic                        sof;
    logic                        eof;

    modport master (output data, valid, sof, eof, input ready);
    modport slave  (input data, valid, sof, eof, output ready);

endinterface

// File: rtl/icnd_skid.sv
// Two-entry skid buffer; in_ready comes from a flop so the upstream never sees out_ready combinationally.
module icnd_skid
    import icnd_pkg::*;
#(
    parameter int WIDTH = WORD_W + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid && !skid_valid_q) begin
            // output stalled: park the incoming word
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/icnd_pattern_gen.sv
// Frame pattern generator: chip-major PWM words scaled by brightness, streamed through icnd_skid.
// Defining ICND_GAMMA_EN squares the level (L*L>>8) before scaling.
module icnd_pattern_gen
    import icnd_pkg::*;
#(
    parameter int CHANNELS = ICND_CHANNELS,
    parameter int CHIP_W   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CHIP_W-1:0]  chipcount,
    input  logic [7:0]         brightness,
    icnd_pattern_gen_if.master bus,
    output logic               done,
    output logic               overrun,
    output logic [7:0]         frame_cnt
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PKT_W  = WORD_W + 2;

    icnd_state_e       state_q, state_d;
    logic [CHIP_W-1:0] chip_idx_q, chip_idx_d;
    logic [CHAN_W-1:0] chan_idx_q, chan_idx_d;
    logic [CHIP_W-1:0] cc_q, cc_d;
    logic [7:0]        br_q, br_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;

    logic              gen_valid, gen_ready, gen_fire;
    logic              first_word, last_chan, last_word, start_ok;
    logic [CHIP_W-1:0] last_chip;
    logic [7:0]        level, level_m;
    logic [WORD_W-1:0] gen_word;
    logic [PKT_W-1:0]  gen_pkt, out_pkt;
    logic              out_valid, out_fire;

    assign last_chip  = cc_q - CHIP_W'(1);
    assign last_chan  = (chan_idx_q == CHAN_W'(CHANNELS - 1));
    assign last_word  = last_chan && (chip_idx_q == last_chip);
    assign first_word = (chip_idx_q == '0) && (chan_idx_q == '0);

    assign level    = frame_cnt_q + 8'({chip_idx_q, 2'b00}) + 8'({chan_idx_q, 4'b0000});
    assign level_m  = icnd_level_map(level);
    assign gen_word = {8'b0, level_m} * {8'b0, br_q};
    assign gen_pkt  = {first_word, last_word, gen_word};

    assign gen_valid = (state_q == ST_RUN);
    assign gen_fire  = gen_valid && gen_ready;
    assign out_fire  = out_valid && bus.ready;
    // a start coinciding with the done pulse is treated as arriving while busy
    assign start_ok  = start && (state_q == ST_IDLE) && !done_q;

    always_comb begin
        state_d     = state_q;
        chip_idx_d  = chip_idx_q;
        chan_idx_d  = chan_idx_q;
        cc_d        = cc_q;
        br_d        = br_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        if (start && !start_ok) overrun_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    cc_d       = chipcount;
                    br_d       = brightness;
                    chip_idx_d = '0;
                    chan_idx_d = '0;
                    state_d    = (chipcount == '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (gen_fire) begin
                    if (last_word) begin
                        state_d = ST_FLUSH;
                    end else if (last_chan) begin
                        chan_idx_d = '0;
                        chip_idx_d = chip_idx_q + CHIP_W'(1);
                    end else begin
                        chan_idx_d = chan_idx_q + CHAN_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // nothing buffered only happens for an empty frame
                if (!out_valid || (out_fire && out_pkt[WORD_W])) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            chip_idx_q  <= '0;
            chan_idx_q  <= '0;
            cc_q        <= '0;
            br_q        <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            chip_idx_q  <= chip_idx_d;
            chan_idx_q  <= chan_idx_d;
            cc_q        <= cc_d;
            br_q        <= br_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    icnd_skid #(.WIDTH(PKT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (gen_valid),
        .in_ready  (gen_ready),
        .in_data   (gen_pkt),
        .out_valid (out_valid),
        .out_data  (out_pkt),
        .out_ready (bus.ready)
    );

    assign bus.valid = out_valid;
    assign bus.sof   = out_pkt[WORD_W+1];
    assign bus.eof   = out_pkt[WORD_W];
    assign bus.data  = out_pkt[WORD_W-1:0];

    assign done      = done_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_icnd_pattern_gen.sv
// Bench for icnd_pattern_gen: directed and randomized frames against a loop-based frame model.
`timescale 1ns/1ps
module tb_icnd_pattern_gen;

    localparam int CH = 16;
    localparam int CW = 9;
`ifdef ICND_GAMMA_EN
    localparam int W1  = ((16 * 16) >> 8) * 255;
    localparam int W16 = ((4 * 4) >> 8) * 255;
    localparam int W31 = ((244 * 244) >> 8) * 255;
`else
    localparam int W1  = 16 * 255;
    localparam int W16 = 4 * 255;
    localparam int W31 = 244 * 255;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] chipcount = '0;
    logic [7:0]    brightness = '0;
    logic          done, overrun;
    logic [7:0]    frame_cnt;

    icnd_pattern_gen_if bus ();

    icnd_pattern_gen #(.CHANNELS(CH), .CHIP_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .chipcount  (chipcount),
        .brightness (brightness),
        .bus        (bus),
        .done       (done),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          eof_cyc = 0;
    int          valid_seen = 0;
    int          ready_mode = 0;
    logic [7:0]  model_fc = 8'd0;
    logic        model_ovr = 1'b0;
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    bit          prev_stall = 0;
    logic [18:0] prev_pkt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // expected frame: every chip, every channel, in chip-major order
    function automatic void build(input int cc, input int br, input int fc);
        exp_q.delete();
        for (int chip = 0; chip < cc; chip++) begin
            for (int ch = 0; ch < CH; ch++) begin
                int l;
                int lp;
                l = (fc + 4 * chip + 16 * ch) % 256;
`ifdef ICND_GAMMA_EN
                lp = (l * l) / 256;
`else
                lp = l;
`endif
                exp_q.push_back({chip == 0 && ch == 0, chip == cc - 1 && ch == CH - 1, 16'(lp * br)});
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {13'b0, bus.valid, bus.sof, bus.eof, bus.data}, {13'b0, prev_pkt});
            if (bus.valid && bus.ready) begin
                obs_q.push_back({bus.sof, bus.eof, bus.data});
                if (bus.eof) eof_cyc = cyc;
            end
            if (bus.valid) valid_seen++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.valid && !bus.ready;
            prev_pkt   = {bus.valid, bus.sof, bus.eof, bus.data};
        end
    end

    initial begin
        bus.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.ready = 1'b1;
                1:       bus.ready = ~bus.ready;
                default: bus.ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic run_frame(input int cc, input int br, input int mode, input bit scramble,
                             input int extra_at, input int rst_at);
        int d0, v0, start_cyc;
        bit got, fired, aborted;
        build(cc, br, int'(model_fc));
        obs_q.delete();
        ready_mode = mode;
        chipcount  = CW'(cc);
        brightness = 8'(br);
        d0 = done_cnt;
        v0 = valid_seen;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc;
        chk("lat_early", {31'b0, bus.valid}, 0);
        got = 0; fired = 0; aborted = 0;
        for (int n = 0; n < 2000 && !got && !aborted; n++) begin
            @(posedge clk); #1;
            if (n == 0) chk("lat_valid", {31'b0, bus.valid}, {31'b0, cc != 0});
            if (scramble) begin
                chipcount  = CW'($urandom);
                brightness = 8'($urandom);
            end
            start = 1'b0;
            if (extra_at >= 0 && !fired && obs_q.size() >= extra_at) begin
                start = 1'b1;
                fired = 1;
                model_ovr = 1'b1;
            end
            if (rst_at >= 0 && obs_q.size() >= rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", {31'b0, bus.valid}, 0);
                chk("rst_data", {16'b0, bus.data}, 0);
                chk("rst_sof_eof", {30'b0, bus.sof, bus.eof}, 0);
                chk("rst_done", {31'b0, done}, 0);
                chk("rst_overrun", {31'b0, overrun}, 0);
                chk("rst_frame_cnt", {24'b0, frame_cnt}, 0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                aborted = 1;
            end
            got = (done_cnt > d0);
        end
        start = 1'b0;
        if (aborted) begin
            repeat (4) @(posedge clk);
            #1;
            chk("rst_no_done", done_cnt - d0, 0);
            model_fc  = 8'd0;
            model_ovr = 1'b0;
            return;
        end
        chk("frame_done", {31'b0, got}, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("done_width", done_cnt - d0, 1);
        chk("n_words", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("word%0d", i), {14'b0, obs_q[i]}, {14'b0, exp_q[i]});
        if (cc == 0) begin
            chk("zero_no_valid", valid_seen - v0, 0);
            chk("zero_done_fast", {31'b0, (done_cyc - start_cyc) <= 3}, 1);
        end else begin
            chk("done_after_eof", done_cyc - eof_cyc, 1);
        end
        model_fc = model_fc + 8'd1;
        chk("frame_cnt", {24'b0, frame_cnt}, {24'b0, model_fc});
        chk("overrun", {31'b0, overrun}, {31'b0, model_ovr});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, bus.valid}, 0);
        chk("reset_data", {16'b0, bus.data}, 0);
        chk("reset_flags", {28'b0, bus.sof, bus.eof, done, overrun}, 0);
        chk("reset_frame_cnt", {24'b0, frame_cnt}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_frame(2, 255, 0, 0, -1, -1);
        if (obs_q.size() == 32) begin
            chk("dir_w0", {14'b0, obs_q[0]}, {14'b0, 2'b10, 16'h0000});
            chk("dir_w1", {14'b0, obs_q[1]}, {14'b0, 2'b00, 16'(W1)});
            chk("dir_w16", {14'b0, obs_q[16]}, {14'b0, 2'b00, 16'(W16)});
            chk("dir_w31", {14'b0, obs_q[31]}, {14'b0, 2'b01, 16'(W31)});
        end

        run_frame(2, 170, 1, 0, -1, -1);
        run_frame(0, 9, 0, 0, -1, -1);
        run_frame(1, 200, 2, 1, -1, -1);
        run_frame(2, 77, 0, 0, 10, -1);

        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(1, 3), $urandom_range(0, 255), $urandom_range(0, 2), 1, -1, -1);

        run_frame(2, 255, 0, 0, -1, 5);
        run_frame(1, 255, 0, 0, -1, -1);
        if (obs_q.size() > 0)
            chk("post_rst_first", {14'b0, obs_q[0]}, {14'b0, 2'b10, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
